// File: rtl/serial_comparator_if.sv
// Request/result bundle of the chunked magnitude comparator.
// The requester drives the master side; the comparator is the slave.
interface serial_comparator_if #(
   parameter int N = 32
);
   logic         start;
   logic         signed_mode;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         busy;
   logic         done;
   logic         lesser;
   logic         equal;
   logic         greater;

   modport master (
      output start, signed_mode, a, b,
      input  busy, done, lesser, equal, greater
   );

   modport slave (
      input  start, signed_mode, a, b,
      output busy, done, lesser, equal, greater
   );
endinterface

// File: rtl/serial_comparator.sv
// Magnitude comparator walking W-bit chunks MSB first, stopping at
// the first differing chunk; signed or unsigned per request.
module serial_comparator #(
   parameter int N = 32,
   parameter int W = 8
) (
   input logic                clk,
   input logic                rst,
   serial_comparator_if.slave bus
);
   localparam int C  = N / W;
   localparam int KW = (C > 1) ? $clog2(C) : 1;
   localparam logic [N-1:0]  MSB_M  = N'(1) << (N - 1);
   localparam logic [KW-1:0] K_LAST = KW'(C - 1);

   typedef enum logic [1:0] {
      IDLE,
      CMP,
      DONE
   } state_t;

   state_t        state_q;
   logic [N-1:0]  a_q;
   logic [N-1:0]  b_q;
   logic [KW-1:0] k_q;
   logic          busy_q;
   logic          done_q;
   logic          lt_q;
   logic          eq_q;
   logic          gt_q;

   // Operands shift left after each equal chunk, so the live chunk
   // always sits in the top W bits.
   logic [W-1:0] ca;
   logic [W-1:0] cb;
   assign ca = a_q[N-1 -: W];
   assign cb = b_q[N-1 -: W];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         k_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         lt_q    <= 1'b0;
         eq_q    <= 1'b0;
         gt_q    <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE, DONE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  // Flipping both sign bits maps two's-complement
                  // order onto unsigned order.
                  a_q     <= bus.a ^ (bus.signed_mode ? MSB_M : '0);
                  b_q     <= bus.b ^ (bus.signed_mode ? MSB_M : '0);
                  k_q     <= '0;
                  busy_q  <= 1'b1;
                  state_q <= CMP;
               end else begin
                  state_q <= IDLE;
               end
            end
            CMP: begin
               if (ca != cb || k_q == K_LAST) begin
                  lt_q    <= ca < cb;
                  eq_q    <= ca == cb;
                  gt_q    <= ca > cb;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  a_q <= a_q << W;
                  b_q <= b_q << W;
                  k_q <= k_q + 1'b1;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.lesser  = lt_q;
   assign bus.equal   = eq_q;
   assign bus.greater = gt_q;
endmodule

// File: tb/tb_serial_comparator.sv
// Scoreboard bench: directed cases on N=32/W=8, random sweep on
// N=16/W=16 and N=16/W=4 against an arithmetic reference.
module tb_serial_comparator;
   typedef struct {
      logic [2:0] fl;
      int         due;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   asserts = 0;
   int   fails = 0;

   exp_t q32[$];
   exp_t qa[$];
   exp_t qb[$];

   serial_comparator_if #(.N(32)) if32 ();
   serial_comparator_if #(.N(16)) ifa ();
   serial_comparator_if #(.N(16)) ifb ();

   serial_comparator #(.N(32), .W(8)) dut32 (
      .clk(clk), .rst(rst), .bus(if32)
   );
   serial_comparator #(.N(16), .W(16)) duta (
      .clk(clk), .rst(rst), .bus(ifa)
   );
   serial_comparator #(.N(16), .W(4)) dutb (
      .clk(clk), .rst(rst), .bus(ifb)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input longint got,
                      input longint exp);
      asserts++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)",
                  nm, got, exp, $time);
      end
   endtask

   // Reference: order from signed/unsigned integer values, latency
   // from the index of the most significant differing chunk.
   function automatic exp_t model(input int n, input int w,
                                  input logic [31:0] a,
                                  input logic [31:0] b,
                                  input bit sm, input int now);
      exp_t   e;
      longint m;
      longint va;
      longint vb;
      longint x;
      int     c;
      int     k;
      m  = (64'sd1 <<< n) - 1;
      va = longint'(a) & m;
      vb = longint'(b) & m;
      x  = va ^ vb;
      if (sm && a[n-1]) va = va - (64'sd1 <<< n);
      if (sm && b[n-1]) vb = vb - (64'sd1 <<< n);
      e.fl = (va < vb) ? 3'b100 : (va == vb) ? 3'b010 : 3'b001;
      c = n / w;
      k = c - 1;
      for (int i = c - 1; i >= 0; i--)
         if (((x >> (n - w - i * w)) & ((64'sd1 <<< w) - 1)) != 0)
            k = i;
      e.due = now + k + 2;
      return e;
   endfunction

   always @(negedge clk) if (!rst && if32.done) begin
      exp_t e;
      chk("done_busy_overlap32", if32.busy, 0);
      if (q32.size() == 0) begin
         chk("unexpected_done32", 1, 0);
      end else begin
         e = q32.pop_front();
         chk("sb_flags32",
             {if32.lesser, if32.equal, if32.greater}, e.fl);
         chk("sb_latency32", cyc, e.due);
      end
   end

   always @(negedge clk) if (!rst && ifa.done) begin
      exp_t e;
      chk("done_busy_overlapA", ifa.busy, 0);
      if (qa.size() == 0) begin
         chk("unexpected_doneA", 1, 0);
      end else begin
         e = qa.pop_front();
         chk("sb_flagsA", {ifa.lesser, ifa.equal, ifa.greater}, e.fl);
         chk("sb_latencyA", cyc, e.due);
      end
   end

   always @(negedge clk) if (!rst && ifb.done) begin
      exp_t e;
      chk("done_busy_overlapB", ifb.busy, 0);
      if (qb.size() == 0) begin
         chk("unexpected_doneB", 1, 0);
      end else begin
         e = qb.pop_front();
         chk("sb_flagsB", {ifb.lesser, ifb.equal, ifb.greater}, e.fl);
         chk("sb_latencyB", cyc, e.due);
      end
   end

   // Called at a negedge with dut32 not busy; returns at the negedge
   // after the DONE cycle.
   task automatic run32(input logic [31:0] a, input logic [31:0] b,
                        input bit sm, input logic [2:0] ef,
                        input int eb);
      int nb = 0;
      int t = 0;
      if32.a = a;
      if32.b = b;
      if32.signed_mode = sm;
      if32.start = 1'b1;
      q32.push_back(model(32, 8, a, b, sm, cyc));
      @(negedge clk);
      if32.start = 1'b0;
      while (!if32.done && t < 50) begin
         if (if32.busy) nb++;
         t++;
         @(negedge clk);
      end
      chk("timeout32", t < 50, 1);
      chk("flags32", {if32.lesser, if32.equal, if32.greater}, ef);
      if (eb >= 0) chk("busy_cycles32", nb, eb);
      @(negedge clk);
   endtask

   task automatic wait_done32;
      int t = 0;
      while (!if32.done && t < 50) begin
         t++;
         @(negedge clk);
      end
      chk("timeout_done32", t < 50, 1);
   endtask

   task automatic wait_idle16;
      int t = 0;
      while ((ifa.busy || ifb.busy) && t < 50) begin
         t++;
         @(negedge clk);
      end
      chk("timeout_idle16", t < 50, 1);
   endtask

   initial begin
      logic [15:0] ra;
      logic [15:0] rb;
      int          sel;
      int          t;
      if32.start = 1'b0;
      if32.signed_mode = 1'b0;
      if32.a = '0;
      if32.b = '0;
      ifa.start = 1'b0;
      ifa.signed_mode = 1'b0;
      ifa.a = '0;
      ifa.b = '0;
      ifb.start = 1'b0;
      ifb.signed_mode = 1'b0;
      ifb.a = '0;
      ifb.b = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_outputs32",
          {if32.busy, if32.done, if32.lesser, if32.equal, if32.greater},
          0);

      run32(32'h80000000, 32'h7FFFFFFF, 1'b0, 3'b001, 1);
      run32(32'h80000000, 32'h7FFFFFFF, 1'b1, 3'b100, 1);
      run32(32'hFFFFFFFF, 32'h00000001, 1'b1, 3'b100, -1);
      run32(32'hFFFFFFFF, 32'h00000001, 1'b0, 3'b001, -1);
      run32(32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 3'b010, 4);
      run32(32'h000000FE, 32'h000000FF, 1'b0, 3'b100, 4);
      run32(32'h12345678, 32'h12345679, 1'b1, 3'b100, 4);
      run32(32'h12005678, 32'h12FF0000, 1'b0, 3'b100, 2);

      // Mid-compare reset: no scoreboard entry, so any done fails.
      if32.a = 32'h12345678;
      if32.b = 32'h12345679;
      if32.signed_mode = 1'b0;
      if32.start = 1'b1;
      @(negedge clk);
      if32.start = 1'b0;
      @(negedge clk);
      chk("busy_before_reset", if32.busy, 1);
      rst = 1'b1;
      #1;
      chk("async_reset_outputs",
          {if32.busy, if32.done, if32.lesser, if32.equal, if32.greater},
          0);
      @(negedge clk);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      chk("idle_after_reset", {if32.busy, if32.done}, 0);

      // start while busy must not disturb the request in flight.
      if32.a = 32'h11223344;
      if32.b = 32'h11223345;
      if32.signed_mode = 1'b0;
      if32.start = 1'b1;
      q32.push_back(model(32, 8, 32'h11223344, 32'h11223345, 1'b0, cyc));
      @(negedge clk);
      if32.start = 1'b0;
      @(negedge clk);
      if32.a = 32'hFFFFFFFF;
      if32.b = 32'h00000000;
      if32.start = 1'b1;
      @(negedge clk);
      if32.start = 1'b0;
      wait_done32();
      chk("ignored_start_flags",
          {if32.lesser, if32.equal, if32.greater}, 3'b100);
      @(negedge clk);

      // Back-to-back: start held into DONE goes straight to CMP.
      if32.a = 32'h80000000;
      if32.b = 32'h7FFFFFFF;
      if32.signed_mode = 1'b0;
      if32.start = 1'b1;
      q32.push_back(model(32, 8, 32'h80000000, 32'h7FFFFFFF, 1'b0, cyc));
      @(negedge clk);
      wait_done32();
      if32.a = 32'hDEADBEEF;
      if32.b = 32'hDEADBEEF;
      q32.push_back(model(32, 8, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, cyc));
      @(negedge clk);
      if32.start = 1'b0;
      chk("b2b_no_idle", {if32.busy, if32.done}, 2'b10);
      wait_done32();
      chk("b2b_flags", {if32.lesser, if32.equal, if32.greater}, 3'b010);
      @(negedge clk);

      // Random sweep on both 16-bit instances in lockstep.
      for (int i = 0; i < 1000; i++) begin
         ra  = 16'($urandom);
         sel = $urandom_range(2);
         if (sel == 0)      rb = 16'($urandom);
         else if (sel == 1) rb = ra;
         else               rb = ra ^ (16'd1 << $urandom_range(15));
         for (int s = 0; s < 2; s++) begin
            wait_idle16();
            ifa.a = ra;
            ifa.b = rb;
            ifa.signed_mode = s[0];
            ifa.start = 1'b1;
            ifb.a = ra;
            ifb.b = rb;
            ifb.signed_mode = s[0];
            ifb.start = 1'b1;
            qa.push_back(model(16, 16, 32'(ra), 32'(rb), s[0], cyc));
            qb.push_back(model(16, 4, 32'(ra), 32'(rb), s[0], cyc));
            @(negedge clk);
            ifa.start = 1'b0;
            ifb.start = 1'b0;
         end
      end

      t = 0;
      while ((q32.size() + qa.size() + qb.size()) != 0 && t < 100) begin
         t++;
         @(negedge clk);
      end
      chk("scoreboard_drained", q32.size() + qa.size() + qb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               asserts, fails);
      $finish;
   end
endmodule

// File: doc/serial_comparator.md
# serial_comparator

Parametrised magnitude comparator that compares two N-bit operands W bits per cycle, MSB chunk first, and stops early at the first differing chunk. It supports runtime signed or unsigned mode and a start/busy/done handshake. It is the successor to the team's combinational lesser/equal/greater comparator. It targets datapaths where a wide single-cycle compare would limit timing or area.

## Interface

Parameters:
- N, default 32: operand width in bits. Must satisfy N >= W and N % W == 0.
- W, default 8: chunk width compared per cycle. Number of chunks C = N/W.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a comparison; accepted only when busy=0.
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with start.
- a  input  N  operand A; sampled with start.
- b  input  N  operand B; sampled with start.
- busy  output  1  high while a comparison is in progress (state CMP).
- done  output  1  one-cycle pulse when result flags become valid.
- lesser  output  1  registered; A < B for the last completed comparison.
- equal  output  1  registered; A == B for the last completed comparison.
- greater  output  1  registered; A > B for the last completed comparison.

## Operation

- States:
  - IDLE: waits for start.
  - CMP: evaluates one chunk per cycle.
  - DONE: asserts done for one cycle, then goes to IDLE.
- On reset: state=IDLE; busy, done, lesser, equal and greater are all 0; chunk counter=0; operand registers=0.
- Accepting a request:
  - start is accepted in IDLE or DONE (busy=0).
  - On acceptance, a, b and signed_mode are captured, the chunk counter is set to 0 (MSB chunk), and the state goes to CMP.
  - start while busy=1 is ignored; it has no effect on the operation in flight.
- Chunk index k = 0 covers bits [N-1 : N-W]; chunk k covers bits [N-1-kW : N-W-kW].
- Signed mode: the MSB of both operands is inverted before the chunk-0 compare. An unsigned compare of the resulting chunks then gives the correct signed order. Later chunks are compared unsigned.
- In each CMP cycle, chunk k of A is compared with chunk k of B:
  - A chunk < B chunk: lesser=1, equal=0, greater=0 at the next edge; go to DONE.
  - A chunk > B chunk: lesser=0, equal=0, greater=1 at the next edge; go to DONE.
  - Chunks equal and k < C-1: k increments, remain in CMP.
  - Chunks equal and k = C-1: lesser=0, equal=1, greater=0 at the next edge; go to DONE.
- Flags are exactly one-hot after the first completed comparison and all-zero before it.
- Flags hold their value through IDLE and through the CMP phase of the next comparison. They change only on the edge that enters DONE.
- Back-to-back: start asserted during DONE is accepted. The state goes DONE -> CMP directly, and done is still a single-cycle pulse.
- Reset mid-operation: immediate abort to the reset state. No done pulse is produced and flags clear to 0.

## Timing

- Latency: with start sampled at edge E0 and operands first differing at chunk k, done is high and flags are valid in the cycle after edge E(k+1).
  - Minimum latency is 1 cycle (k=0).
  - Maximum latency is C cycles (operands differ only in the last chunk, or are equal).
- busy is high from the cycle after E0 through the last CMP cycle, and low in DONE and IDLE.
- done is high for exactly one cycle per accepted start; it is never high concurrently with busy.
- Throughput: with start held high, one result every (decision chunk + 2) cycles, since one DONE cycle is inserted between operations.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan

- Reset and idle: assert rst mid-CMP (N=32, W=8, a=0x12345678, b=0x12345679, after 2 cycles) -> all outputs 0 immediately, no done; after release, state is IDLE.
- Early exit, unsigned: a=0x80000000, b=0x7FFFFFFF, signed_mode=0 -> done 1 cycle after start edge; greater=1, others 0.
- Signed mode: same operands with signed_mode=1 -> done after 1 cycle, lesser=1. Also a=0xFFFFFFFF, b=0x00000001, signed_mode=1 -> lesser=1; same operands with signed_mode=0 -> greater=1.
- Full-depth compare: a=b=0xDEADBEEF -> busy high for 4 cycles, done after 4 cycles, equal=1. Then a=0x000000FE, b=0x000000FF -> lesser=1 after 4 cycles.
- Handshake: start pulsed while busy with new operands -> ignored, and the original result is reported. start held during DONE -> next compare starts with no IDLE cycle; done pulses exactly once per accepted start.
- Parameter sweep: N=16, W=16 (C=1) and N=16, W=4 (C=4) against a random reference model over 1000 operand pairs in both modes -> flags match, and latency equals first differing chunk index + 1.
